// File: rtl/ssp_pkg.sv
// ssp_pkg: shared types and constants for the SSP transmit serialiser.
//   frame_state_t : frame FSM states (IDLE, FRAME, SHIFT)
//   req_state_t   : FIFO request FSM states (REQ, WAIT1, WAIT2)
//   SSP_DATA_W    : default bits per frame
package ssp_pkg;

    localparam int unsigned SSP_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        SHIFT
    } frame_state_t;

    typedef enum logic [1:0] {
        REQ,
        WAIT1,
        WAIT2
    } req_state_t;

endpackage

// File: rtl/ssp_tx_shifter_if.sv
// ssp_tx_shifter_if: byte handshake between the SSP transmit FIFO and the serialiser.
//   TxData            : byte from FIFO, valid only while tx_ready=1
//   tx_ready          : FIFO 1-cycle strobe, TxData valid this cycle
//   transmit_complete : 1-cycle request pulse from serialiser for the next byte
//   master modport = FIFO side, slave modport = serialiser side.
interface ssp_tx_shifter_if #(
    parameter int unsigned DATA_W = ssp_pkg::SSP_DATA_W
);

    logic [DATA_W-1:0] TxData;
    logic              tx_ready;
    logic              transmit_complete;

    modport master (
        output TxData,
        output tx_ready,
        input  transmit_complete
    );

    modport slave (
        input  TxData,
        input  tx_ready,
        output transmit_complete
    );

endinterface

// File: rtl/ssp_bit_timer.sv
// ssp_bit_timer: bit-period counter for the SSP serial clock.
//   PCLK       : system clock
//   CLEAR      : asynchronous active-high reset
//   restart    : synchronous restart, counter is 0 on the following cycle
//   phase_nxt  : 1 when the next cycle lies in the high half of a bit period
//   end_of_bit : 1 on the last PCLK cycle of the current bit period
// A bit period is 2*CLK_DIV PCLK cycles. phase_nxt is a look-ahead so the
// parent can register SSPCLKOUT without adding a cycle of skew.
module ssp_bit_timer #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic PCLK,
    input  logic CLEAR,
    input  logic restart,
    output logic phase_nxt,
    output logic end_of_bit
);

    localparam int unsigned   CW   = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        end_of_bit = (cnt == LAST);
        if (restart || end_of_bit) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
        phase_nxt = (cnt_nxt < HALF);
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ssp_tx_shifter.sv
// ssp_tx_shifter: SSP transmit serialiser, TI synchronous-serial framing.
//   PCLK      : system clock, all logic on posedge
//   CLEAR     : asynchronous active-high reset
//   fifo      : byte handshake with the transmit FIFO (TxData, tx_ready, transmit_complete)
//   SSPTXD    : serial data, MSB first
//   SSPCLKOUT : serial clock, high in the first half of each bit period
//   SSPFSSOUT : frame sync, high for the bit period before the MSB
//   SSPOE_B   : pad output enable, active low
//   busy      : frame in progress or holding register full
// Bytes are double-buffered (holding reg + shift reg) so the next byte is
// fetched while the current one shifts, giving gap-free back-to-back frames.
module ssp_tx_shifter import ssp_pkg::*; #(
    parameter int unsigned DATA_W  = SSP_DATA_W,
    parameter int unsigned CLK_DIV = 1
) (
    input  logic                   PCLK,
    input  logic                   CLEAR,
    ssp_tx_shifter_if.slave        fifo,
    output logic                   SSPTXD,
    output logic                   SSPCLKOUT,
    output logic                   SSPFSSOUT,
    output logic                   SSPOE_B,
    output logic                   busy
);

    localparam int unsigned    BCW      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    frame_state_t      frame_state, frame_nxt;
    req_state_t        req_state, req_nxt;
    logic [DATA_W-1:0] hold, shift, shift_nxt;
    logic              hold_valid, hold_valid_nxt;
    logic [BCW-1:0]    bit_cnt, bit_cnt_nxt;
    logic              capture, load;
    logic              phase_nxt, end_of_bit;
    logic              txd_nxt, sclk_nxt, fss_nxt, oe_b_nxt;

    // Timer is held at zero while idle, so each new burst starts on a fresh bit period.
    ssp_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .PCLK       (PCLK),
        .CLEAR      (CLEAR),
        .restart    (frame_state == IDLE),
        .phase_nxt  (phase_nxt),
        .end_of_bit (end_of_bit)
    );

    // State register, datapath and registered pins.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            frame_state <= IDLE;
            req_state   <= REQ;
            hold        <= '0;
            hold_valid  <= 1'b0;
            shift       <= '0;
            bit_cnt     <= '0;
            SSPTXD      <= 1'b0;
            SSPCLKOUT   <= 1'b0;
            SSPFSSOUT   <= 1'b0;
            SSPOE_B     <= 1'b1;
        end else begin
            frame_state <= frame_nxt;
            req_state   <= req_nxt;
            hold_valid  <= hold_valid_nxt;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            if (capture) begin
                hold <= fifo.TxData;
            end
            SSPTXD    <= txd_nxt;
            SSPCLKOUT <= sclk_nxt;
            SSPFSSOUT <= fss_nxt;
            SSPOE_B   <= oe_b_nxt;
        end
    end

    // Next-state logic for both FSMs and the datapath.
    always_comb begin
        frame_nxt   = frame_state;
        load        = 1'b0;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        case (frame_state)
            IDLE: begin
                if (hold_valid) begin
                    load      = 1'b1;
                    frame_nxt = FRAME;
                end
            end
            FRAME: begin
                if (end_of_bit) begin
                    frame_nxt   = SHIFT;
                    bit_cnt_nxt = '0;
                end
            end
            SHIFT: begin
                if (end_of_bit) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_nxt = '0;
                        if (hold_valid) begin
                            load      = 1'b1;
                            frame_nxt = FRAME;
                        end else begin
                            frame_nxt = IDLE;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        shift_nxt   = {shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: frame_nxt = IDLE;
        endcase
        // Transfer reads the old hold value; a same-edge capture overwrites hold.
        if (load) begin
            shift_nxt = hold;
        end

        capture = (req_state == WAIT1) && fifo.tx_ready;
        req_nxt = req_state;
        case (req_state)
            REQ:     if (!hold_valid) req_nxt = WAIT1;
            WAIT1:   req_nxt = capture ? REQ : WAIT2;
            WAIT2:   req_nxt = REQ;
            default: req_nxt = REQ;
        endcase

        if (capture) begin
            hold_valid_nxt = 1'b1;
        end else if (load) begin
            hold_valid_nxt = 1'b0;
        end else begin
            hold_valid_nxt = hold_valid;
        end
    end

    // Outputs. Pins are decoded from next-state values and registered above,
    // so they line up with the state they describe.
    always_comb begin
        fifo.transmit_complete = (req_state == REQ) && !hold_valid && !CLEAR;
        oe_b_nxt = (frame_nxt == IDLE);
        fss_nxt  = (frame_nxt == FRAME);
        txd_nxt  = !oe_b_nxt && shift_nxt[DATA_W-1];
        sclk_nxt = !oe_b_nxt && phase_nxt;
        busy     = (frame_state != IDLE) || hold_valid;
    end

endmodule
